// File: rtl/energy_accumulator_pkg.sv
// Shared types and width helpers for the Ising energy accumulator.
// Parameter defaults of the accumulator and its sub-module are derived from these.
package energy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int calc_dot_width(input int vector_size, input int j_width);
        return $clog2(vector_size) + j_width;
    endfunction

    // One spare bit beyond the worst-case column sum keeps negation of the most negative dot exact.
    function automatic int calc_energy_width(input int vector_size, input int j_width);
        return calc_dot_width(vector_size, j_width) + $clog2(vector_size) + 1;
    endfunction

endpackage

// File: rtl/adder_subtractor_unit.sv
// Combinational two's-complement add/subtract: y = sub ? a - b : a + b.
// Shared with the sigma-controlled dot-product chain so both use the same sign convention.
module adder_subtractor_unit #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/energy_accumulator.sv
// Accumulates E_raw = sum_j s_j * h_j from a stream of column dot products,
// where s_j = +1 for sigma bit 0 and -1 for sigma bit 1.
module energy_accumulator
    import energy_pkg::*;
#(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int DOT_WIDTH       = calc_dot_width(VECTOR_SIZE, J_ELEMENT_WIDTH),
    parameter int ENERGY_WIDTH    = calc_energy_width(VECTOR_SIZE, J_ELEMENT_WIDTH),
    parameter int IDX_WIDTH       = $clog2(VECTOR_SIZE)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [VECTOR_SIZE-1:0]         sigma_i,
    input  logic                           dot_valid_i,
    output logic                           dot_ready_o,
    input  logic signed [DOT_WIDTH-1:0]    dot_i,
    output logic [IDX_WIDTH-1:0]           col_idx_o,
    output logic                           busy_o,
    output logic                           energy_valid_o,
    input  logic                           energy_ready_i,
    output logic signed [ENERGY_WIDTH-1:0] energy_o
);

    state_t state, next_state;

    logic [VECTOR_SIZE-1:0]         sigma_q;
    logic signed [ENERGY_WIDTH-1:0] acc;
    logic signed [ENERGY_WIDTH-1:0] acc_next;
    logic signed [ENERGY_WIDTH-1:0] energy_q;
    logic signed [ENERGY_WIDTH-1:0] dot_ext;
    logic [IDX_WIDTH-1:0]           col;

    logic dot_hs;
    logic energy_hs;
    logic last_col;
    logic load;

    assign dot_ext   = {{(ENERGY_WIDTH-DOT_WIDTH){dot_i[DOT_WIDTH-1]}}, dot_i};
    assign dot_hs    = (state == ACCUM) && dot_valid_i;
    assign energy_hs = (state == DONE) && energy_ready_i;
    assign last_col  = (col == IDX_WIDTH'(VECTOR_SIZE - 1));
    // A start is honoured from IDLE, or chained onto the result handshake to avoid an IDLE bubble.
    assign load      = ((state == IDLE) && start_i) || (energy_hs && start_i);

    adder_subtractor_unit #(
        .WIDTH (ENERGY_WIDTH)
    ) u_addsub (
        .a   (acc),
        .b   (dot_ext),
        .sub (sigma_q[col]),
        .y   (acc_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_i) next_state = ACCUM;
            ACCUM:   if (dot_valid_i && last_col) next_state = DONE;
            DONE:    if (energy_ready_i) next_state = start_i ? ACCUM : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sigma_q is a plain register, not a memory, so it is cleared with everything else on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sigma_q  <= '0;
            acc      <= '0;
            col      <= '0;
            energy_q <= '0;
        end else if (load) begin
            sigma_q <= sigma_i;
            acc     <= '0;
            col     <= '0;
        end else if (dot_hs) begin
            acc <= acc_next;
            if (last_col) begin
                energy_q <= acc_next;
                col      <= '0;
            end else begin
                col <= col + IDX_WIDTH'(1);
            end
        end
    end

    assign dot_ready_o    = (state == ACCUM);
    assign energy_valid_o = (state == DONE);
    assign busy_o         = (state != IDLE);
    assign col_idx_o      = (state == ACCUM) ? col : '0;
    assign energy_o       = energy_q;

endmodule

// File: tb/tb_energy_accumulator.sv
// Self-checking bench for energy_accumulator with VECTOR_SIZE=4 (DOT_WIDTH=6, ENERGY_WIDTH=9),
// comparing against a signed-sum reference model.
module tb_energy_accumulator;

    localparam int VS = 4;
    localparam int DW = 6;
    localparam int EW = 9;
    localparam int IW = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 start_i = 1'b0;
    logic [VS-1:0]        sigma_i = '0;
    logic                 dot_valid_i = 1'b0;
    logic                 dot_ready_o;
    logic signed [DW-1:0] dot_i = '0;
    logic [IW-1:0]        col_idx_o;
    logic                 busy_o;
    logic                 energy_valid_o;
    logic                 energy_ready_i = 1'b0;
    logic signed [EW-1:0] energy_o;

    int vectors = 0;
    int miscompares = 0;
    int dots[VS];

    energy_accumulator #(
        .VECTOR_SIZE (VS)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .sigma_i        (sigma_i),
        .dot_valid_i    (dot_valid_i),
        .dot_ready_o    (dot_ready_o),
        .dot_i          (dot_i),
        .col_idx_o      (col_idx_o),
        .busy_o         (busy_o),
        .energy_valid_o (energy_valid_o),
        .energy_ready_i (energy_ready_i),
        .energy_o       (energy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: E_raw = sum over columns of (+dot) for sigma bit 0, (-dot) for sigma bit 1.
    function automatic int model_energy(input logic [VS-1:0] sig);
        int e = 0;
        for (int j = 0; j < VS; j++) e += sig[j] ? -dots[j] : dots[j];
        return e;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_dot_ready"}, dot_ready_o, 0);
        check({tag, "_energy_valid"}, energy_valid_o, 0);
        check({tag, "_col"}, col_idx_o, 0);
    endtask

    // Starts from IDLE; leaves the DUT in ACCUM with inputs driven at a negedge.
    task automatic begin_eval(input logic [VS-1:0] sig);
        @(negedge clk_i);
        start_i = 1'b1;
        sigma_i = sig;
        @(negedge clk_i);
        start_i = 1'b0;
        sigma_i = ~sig;
        check("start_busy", busy_o, 1);
        check("start_dot_ready", dot_ready_o, 1);
        check("start_col", col_idx_o, 0);
    endtask

    // Feeds all columns (optionally with gaps and spurious start_i), then checks the DONE result
    // and holds energy_ready_i low for 'hold' cycles while poking ignored inputs.
    task automatic feed_and_check(input logic [VS-1:0] sig, input bit gaps, input bit noise, input int hold);
        int exp;
        exp = model_energy(sig);
        for (int j = 0; j < VS; j++) begin
            if (gaps) begin
                int idle_cycles;
                idle_cycles = $urandom_range(0, 2);
                for (int k = 0; k < idle_cycles; k++) begin
                    dot_valid_i = 1'b0;
                    dot_i = DW'($urandom);
                    check("gap_col", col_idx_o, j);
                    @(negedge clk_i);
                end
            end
            dot_valid_i = 1'b1;
            dot_i = DW'(dots[j]);
            start_i = noise;
            sigma_i = ~sig;
            check("accum_col", col_idx_o, j);
            check("accum_dot_ready", dot_ready_o, 1);
            check("accum_energy_valid", energy_valid_o, 0);
            @(negedge clk_i);
        end
        dot_valid_i = 1'b0;
        start_i = 1'b0;
        check("done_energy_valid", energy_valid_o, 1);
        check("done_dot_ready", dot_ready_o, 0);
        check("done_col", col_idx_o, 0);
        check("done_energy", $signed(energy_o), exp);
        for (int k = 0; k < hold; k++) begin
            energy_ready_i = 1'b0;
            dot_valid_i = 1'b1;
            dot_i = DW'($urandom);
            start_i = k[0];
            @(negedge clk_i);
            check("hold_energy_valid", energy_valid_o, 1);
            check("hold_dot_ready", dot_ready_o, 0);
            check("hold_energy", $signed(energy_o), exp);
        end
        dot_valid_i = 1'b0;
        start_i = 1'b0;
    endtask

    // Completes the energy handshake, optionally chaining a new start with sigma nsig.
    task automatic release_result(input bit chain, input logic [VS-1:0] nsig);
        energy_ready_i = 1'b1;
        start_i = chain;
        sigma_i = nsig;
        @(negedge clk_i);
        energy_ready_i = 1'b0;
        start_i = 1'b0;
        sigma_i = ~nsig;
        if (chain) begin
            check("chain_busy", busy_o, 1);
            check("chain_dot_ready", dot_ready_o, 1);
            check("chain_energy_valid", energy_valid_o, 0);
            check("chain_col", col_idx_o, 0);
        end else begin
            check_idle_outputs("release");
        end
    endtask

    task automatic run_eval(input logic [VS-1:0] sig, input bit gaps, input bit noise, input int hold);
        begin_eval(sig);
        feed_and_check(sig, gaps, noise, hold);
        release_result(1'b0, '0);
    endtask

    initial begin
        #1;
        check_idle_outputs("reset");
        check("reset_energy", $signed(energy_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        dot_valid_i = 1'b1;
        @(negedge clk_i);
        dot_valid_i = 1'b0;
        check_idle_outputs("idle_dot_ignored");

        dots = '{1, 2, 3, 4};
        run_eval(4'b0000, 1'b0, 1'b0, 0);

        dots = '{5, -3, 7, 2};
        run_eval(4'b0101, 1'b0, 1'b0, 0);

        dots = '{-32, -32, -32, -32};
        run_eval(4'b1111, 1'b0, 1'b0, 0);
        run_eval(4'b0000, 1'b0, 1'b0, 0);

        dots = '{5, -3, 7, 2};
        run_eval(4'b0101, 1'b1, 1'b0, 5);

        // Asynchronous reset after two column handshakes.
        dots = '{9, 9, 9, 9};
        begin_eval(4'b0110);
        for (int j = 0; j < 2; j++) begin
            dot_valid_i = 1'b1;
            dot_i = DW'(dots[j]);
            @(negedge clk_i);
        end
        dot_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check_idle_outputs("midreset");
        check("midreset_energy", $signed(energy_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        dots = '{1, 2, 3, 4};
        run_eval(4'b0000, 1'b0, 1'b0, 0);

        // Spurious start_i during ACCUM, then a chained start from DONE.
        dots = '{5, -3, 7, 2};
        begin_eval(4'b0101);
        feed_and_check(4'b0101, 1'b0, 1'b1, 2);
        release_result(1'b1, 4'b1010);
        dots = '{-7, 11, -32, 31};
        feed_and_check(4'b1010, 1'b1, 1'b0, 1);
        release_result(1'b0, '0);

        for (int n = 0; n < 20; n++) begin
            logic [VS-1:0] sig;
            sig = VS'($urandom);
            for (int j = 0; j < VS; j++) dots[j] = int'($urandom_range(0, 63)) - 32;
            run_eval(sig, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
